rc_pwm_multi: RTL and testbench



---
 rtl/rc_pwm_multi.sv | 159 +++++++++++++++
 tb/tb_rc_pwm_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rc_pwm_multi.sv
// rc_pwm_multi: multi-channel RC servo/ESC pulse generator.
// One shared prescaler/us counter sets the frame; each channel holds a shadow
// width (written by iVALID) and an active width (loaded only at frame start),
// so a pulse never changes length part-way through a frame. A frame-miss
// counter drops every channel to the neutral width when commands stop.
module rc_pwm_multi #(
    parameter int NCH       = 4,
    parameter int VW        = 8,
    parameter int TICK_DIV  = 48,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int FS_US     = 1500,
    parameter int SLEW_US   = 0,
    parameter int FS_FRAMES = 25
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic [NCH*VW-1:0] iVAL,
    input  logic              iVALID,
    input  logic [NCH-1:0]    iEN,
    output logic [NCH-1:0]    oPWM,
    output logic              oFRAME,
    output logic              oFAILSAFE
);

    localparam int PSW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int UW   = $clog2(FRAME_US);
    localparam int WW   = $clog2(FRAME_US + 1);
    localparam int SPAN = MAX_US - MIN_US;
    localparam int PW   = VW + $clog2(SPAN + 1);
    localparam int MW   = $clog2(FS_FRAMES + 1);

    // The pulse must end inside the frame, otherwise it would merge with the next one.
    generate
        if (MAX_US >= FRAME_US) begin : g_param_check
            $error("rc_pwm_multi: MAX_US must be smaller than FRAME_US");
        end
    endgenerate

    logic [PSW-1:0] presc_q, presc_d;
    logic [UW-1:0]  us_q, us_d;
    logic [MW-1:0]  miss_q, miss_d;
    logic           fs_q, fs_d;
    logic           frame_q, frame_d;
    logic [NCH-1:0] pwm_q, pwm_d;
    logic [WW-1:0]  shadow_q [NCH];
    logic [WW-1:0]  shadow_d [NCH];
    logic [WW-1:0]  active_q [NCH];
    logic [WW-1:0]  active_d [NCH];

    logic tick;
    logic boundary;

    // One step of at most SLEW_US from cur toward tgt.
    function automatic logic [WW-1:0] slew_step(input logic [WW-1:0] cur,
                                                input logic [WW-1:0] tgt);
        logic signed [WW+1:0] diff;
        logic signed [WW+1:0] lim;
        lim  = (WW+2)'(SLEW_US);
        diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        if (diff > lim) begin
            diff = lim;
        end else if (diff < -lim) begin
            diff = -lim;
        end
        slew_step = WW'($signed({2'b00, cur}) + diff);
    endfunction

    assign tick     = (presc_q == PSW'(TICK_DIV - 1));
    // Counters sit at zero after reset, so the first cycle out of reset is a boundary too.
    assign boundary = (presc_q == '0) && (us_q == '0);

    // Shared timebase: prescaler to 1 us ticks, us counter spans one frame.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PSW'(1);
        us_d    = us_q;
        if (tick) begin
            us_d = (us_q == UW'(FRAME_US - 1)) ? '0 : us_q + UW'(1);
        end
        frame_d = boundary;
    end

    // Command timeout: boundaries without iVALID count up to failsafe; iVALID wins.
    always_comb begin
        miss_d = miss_q;
        fs_d   = fs_q;
        if (boundary && (miss_q != MW'(FS_FRAMES))) begin
            miss_d = miss_q + MW'(1);
        end
        if (miss_d == MW'(FS_FRAMES)) begin
            fs_d = 1'b1;
        end
        if (iVALID) begin
            miss_d = '0;
            fs_d   = 1'b0;
        end
    end

    // Shadow widths from commands; active widths move only on a frame boundary.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (iVALID) begin
                shadow_d[i] = WW'(MIN_US) +
                              WW'((PW'(iVAL[i*VW +: VW]) * PW'(SPAN)) >> VW);
            end
            active_d[i] = active_q[i];
            if (boundary) begin
                if (fs_q) begin
                    active_d[i] = WW'(FS_US);
                end else if (SLEW_US == 0) begin
                    active_d[i] = shadow_q[i];
                end else begin
                    active_d[i] = slew_step(active_q[i], shadow_q[i]);
                end
            end
        end
    end

    // Pulse compare against the active width, gated by the channel enable.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = iEN[i] && (WW'(us_q) < active_q[i]);
        end
    end

    // State registers; reset clears outputs at once and restarts the frame.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            presc_q <= '0;
            us_q    <= '0;
            miss_q  <= '0;
            fs_q    <= 1'b1;
            frame_q <= 1'b0;
            pwm_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= WW'(FS_US);
                active_q[i] <= WW'(FS_US);
            end
        end else begin
            presc_q <= presc_d;
            us_q    <= us_d;
            miss_q  <= miss_d;
            fs_q    <= fs_d;
            frame_q <= frame_d;
            pwm_q   <= pwm_d;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign oPWM      = pwm_q;
    assign oFRAME    = frame_q;
    assign oFAILSAFE = fs_q;

endmodule

// File: tb/tb_rc_pwm_multi.sv
// Directed bench for rc_pwm_multi with a shrunken timebase (2 clocks/us,
// 300 us frame, 100..200 us span, 150 us neutral, 4-frame timeout).
// dut0 has no slew limit, dut1 limits to 10 us per frame.
module tb_rc_pwm_multi;

    localparam int NCH       = 4;
    localparam int FRAME_CYC = 600;

    logic            clk;
    logic            rst_n;
    logic [31:0]     ival;
    logic            ivalid;
    logic [3:0]      ien;
    logic [3:0]      pwm0, pwm1;
    logic            frame0, frame1;
    logic            fs0, fs1;

    int n_total;
    int n_pass;
    int cnt0 [NCH];
    int cnt1 [NCH];
    int extra;

    int          kind [22];
    logic [31:0] sval [22];
    int          exp0 [22][4];
    int          exp1 [22][4];
    int          expfs [22];

    rc_pwm_multi #(
        .NCH(4), .VW(8), .TICK_DIV(2), .FRAME_US(300), .MIN_US(100), .MAX_US(200),
        .FS_US(150), .SLEW_US(0), .FS_FRAMES(4)
    ) dut0 (
        .iCLK(clk), .iRESETn(rst_n), .iVAL(ival), .iVALID(ivalid), .iEN(ien),
        .oPWM(pwm0), .oFRAME(frame0), .oFAILSAFE(fs0)
    );

    rc_pwm_multi #(
        .NCH(4), .VW(8), .TICK_DIV(2), .FRAME_US(300), .MIN_US(100), .MAX_US(200),
        .FS_US(150), .SLEW_US(10), .FS_FRAMES(4)
    ) dut1 (
        .iCLK(clk), .iRESETn(rst_n), .iVAL(ival), .iVALID(ivalid), .iEN(ien),
        .oPWM(pwm1), .oFRAME(frame1), .oFAILSAFE(fs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic strobe(input logic [31:0] v);
        ival   = v;
        ivalid = 1'b1;
        @(negedge clk);
        ivalid = 1'b0;
    endtask

    // Starts on the negedge where oFRAME is high; counts high cycles over one frame.
    task automatic measure_frame();
        for (int c = 0; c < NCH; c++) begin
            cnt0[c] = 0;
            cnt1[c] = 0;
        end
        extra = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (pwm0[c]) cnt0[c]++;
                if (pwm1[c]) cnt1[c]++;
            end
            if (k > 0 && (frame0 || frame1)) extra++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        ival    = '0;
        ivalid  = 1'b0;
        ien     = 4'hF;

        // kind: 0 none, 1 strobe mid-frame, 2 strobe on the next boundary cycle
        kind  = '{0,1,2,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0};
        sval  = '{32'h0, 32'h40FF8000, 32'h8000FF00, 32'h8000FF00, 32'h8000FF00,
                  32'h8000FF00, 32'h8000FFFF, 32'h8000FFFF, 32'h8000FFFF, 32'h8000FFFF,
                  32'h8000FFFF, 32'h8000FFFF, 32'h8000FFFF, 32'h8000FFFF, 32'h8000FFFF,
                  32'h8000FFFF, 32'h8000FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        expfs = '{1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1};
        exp0  = '{'{150,150,150,150}, '{150,150,150,150}, '{100,150,199,125},
                  '{100,150,199,125}, '{100,199,100,150}, '{100,199,100,150},
                  '{100,199,100,150}, '{199,199,100,150}, '{199,199,100,150},
                  '{199,199,100,150}, '{199,199,100,150}, '{199,199,100,150},
                  '{199,199,100,150}, '{199,199,100,150}, '{199,199,100,150},
                  '{199,199,100,150}, '{199,199,100,150}, '{199,199,100,150},
                  '{199,199,100,150}, '{199,199,100,150}, '{199,199,100,150},
                  '{150,150,150,150}};
        exp1  = '{'{150,150,150,150}, '{150,150,150,150}, '{140,150,160,140},
                  '{130,150,170,130}, '{120,160,160,140}, '{110,170,150,150},
                  '{100,180,140,150}, '{110,190,130,150}, '{120,199,120,150},
                  '{130,199,110,150}, '{140,199,100,150}, '{150,199,100,150},
                  '{160,199,100,150}, '{170,199,100,150}, '{180,199,100,150},
                  '{190,199,100,150}, '{199,199,100,150}, '{199,199,100,150},
                  '{199,199,100,150}, '{199,199,100,150}, '{199,199,100,150},
                  '{150,150,150,150}};

        repeat (3) @(negedge clk);
        check("reset_pwm0", {28'd0, pwm0}, 32'd0);
        check("reset_pwm1", {28'd0, pwm1}, 32'd0);
        check("reset_frame", {31'd0, frame0}, 32'd0);
        check("reset_fs", {31'd0, fs0}, 32'd1);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_frame", {31'd0, frame0}, 32'd1);

        for (int f = 0; f < 22; f++) begin
            check($sformatf("f%0d_fs0", f + 1), {31'd0, fs0}, expfs[f]);
            check($sformatf("f%0d_fs1", f + 1), {31'd0, fs1}, expfs[f]);
            fork
                measure_frame();
                begin
                    if (kind[f] == 1) begin
                        repeat (100) @(negedge clk);
                        strobe(sval[f]);
                        check($sformatf("f%0d_fs_clear", f + 1), {31'd0, fs0 | fs1}, 32'd0);
                    end else if (kind[f] == 2) begin
                        repeat (FRAME_CYC - 1) @(negedge clk);
                        strobe(sval[f]);
                    end
                end
            join
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("f%0d_d0_ch%0d", f + 1, c), cnt0[c], 2 * exp0[f][c]);
                check($sformatf("f%0d_d1_ch%0d", f + 1, c), cnt1[c], 2 * exp1[f][c]);
            end
            check($sformatf("f%0d_no_extra_frame", f + 1), extra, 32'd0);
            check($sformatf("f%0d_frame_period", f + 1), {31'd0, frame0 & frame1}, 32'd1);
        end

        // Frame 23 runs neutral widths; exercise enable and reset mid-pulse.
        repeat (50) @(negedge clk);
        check("pre_toggle", {28'd0, pwm0}, 32'hF);
        ien = 4'b1101;
        @(negedge clk);
        check("en_low_d0", {28'd0, pwm0}, 32'hD);
        check("en_low_d1", {28'd0, pwm1}, 32'hD);
        ien = 4'hF;
        @(negedge clk);
        check("en_restore", {28'd0, pwm0}, 32'hF);
        repeat (20) @(negedge clk);
        check("pre_reset", {28'd0, pwm1}, 32'hF);
        rst_n = 1'b0;
        #1;
        check("async_pwm0", {28'd0, pwm0}, 32'd0);
        check("async_pwm1", {28'd0, pwm1}, 32'd0);
        check("async_fs", {31'd0, fs1}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_frame", {31'd0, frame0}, 32'd1);
        measure_frame();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("restart_d0_ch%0d", c), cnt0[c], 32'd300);
        end
        check("restart_period", {31'd0, frame0}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
